// File: rtl/div_if.sv
// Request/response bundle between the execute stage (master) and the
// 32-bit restoring divider (slave).
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Optional feature: define DIV_ANNUL_EN to let annul_i abort a division.
module div (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state_reg;
  logic [5:0]  cnt_reg;
  logic [64:0] work_reg;
  logic [31:0] divisor_reg;
  logic        neg1_reg;
  logic        neg2_reg;
  logic [63:0] result_reg;
  logic        ready_reg;

  logic        annul_act;
  logic [32:0] diff;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

`ifdef DIV_ANNUL_EN
  assign annul_act = bus.annul_i;
`else
  assign annul_act = bus.annul_i & 1'b0;
`endif

  always_comb begin
    diff = {1'b0, work_reg[63:32]} - {1'b0, divisor_reg};
    mag1 = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    mag2 = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
    // Quotient is negative when signs differ; remainder follows the dividend.
    quot_fix = (neg1_reg ^ neg2_reg) ? (~work_reg[31:0] + 32'd1) : work_reg[31:0];
    rem_fix  = neg1_reg ? (~work_reg[64:33] + 32'd1) : work_reg[64:33];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= FREE;
      cnt_reg     <= 6'd0;
      work_reg    <= 65'd0;
      divisor_reg <= 32'd0;
      neg1_reg    <= 1'b0;
      neg2_reg    <= 1'b0;
      result_reg  <= 64'd0;
      ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        FREE: begin
          if (bus.start_i && !annul_act) begin
            if (bus.opdata2_i == 32'd0) begin
              state_reg <= BYZERO;
            end else begin
              state_reg   <= ON;
              cnt_reg     <= 6'd0;
              work_reg    <= {32'd0, mag1, 1'b0};
              divisor_reg <= mag2;
              neg1_reg    <= bus.signed_div_i & bus.opdata1_i[31];
              neg2_reg    <= bus.signed_div_i & bus.opdata2_i[31];
            end
          end
        end
        BYZERO: begin
          if (annul_act) begin
            state_reg <= FREE;
          end else begin
            state_reg  <= END;
            result_reg <= 64'd0;
            ready_reg  <= 1'b1;
          end
        end
        ON: begin
          if (annul_act) begin
            state_reg <= FREE;
            cnt_reg   <= 6'd0;
          end else if (!cnt_reg[5]) begin
            if (diff[32]) begin
              work_reg <= work_reg << 1;
            end else begin
              work_reg <= {diff[31:0], work_reg[31:0], 1'b1};
            end
            cnt_reg <= cnt_reg + 6'd1;
          end else begin
            state_reg  <= END;
            result_reg <= {rem_fix, quot_fix};
            ready_reg  <= 1'b1;
            cnt_reg    <= 6'd0;
          end
        end
        END: begin
          if (!bus.start_i) begin
            state_reg  <= FREE;
            result_reg <= 64'd0;
            ready_reg  <= 1'b0;
          end
        end
        default: state_reg <= FREE;
      endcase
    end
  end

  assign bus.result_o = result_reg;
  assign bus.ready_o  = ready_reg;

endmodule

// File: tb/tb_div.sv
// Randomized self-checking bench for div; results are predicted with plain
// integer arithmetic on operand magnitudes.
module tb_div;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  div_if bus ();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ma, mb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q  = ma / mb;
    r  = ma % mb;
    if ((sa < 0) != (sb < 0)) q = -q;
    if (sa < 0) r = -r;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Full transaction: start held until ready, checked latency/result/hold, then release.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp_v;
    int lat;
    exp_v = ref_div(sgn, a, b);
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    @(posedge clk);
    #1;
    bus.opdata1_i    = $urandom;
    bus.opdata2_i    = $urandom;
    bus.signed_div_i = ~sgn;
    lat = 0;
    while (!bus.ready_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
    check({tag, "_result"}, bus.result_o, exp_v);
    $display("div %s sgn=%0d %h / %h -> ready after %0d, result %h", tag, sgn, a, b, lat, bus.result_o);
    @(posedge clk);
    #1;
    check({tag, "_hold"}, {bus.result_o[62:0], bus.ready_o}, {exp_v[62:0], 1'b1});
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_release"}, {bus.result_o[62:0], bus.ready_o}, 64'd0);
  endtask

  initial begin
    bit seen;
    bit sgn;
    logic [31:0] a, b;
    int lat;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("reset_ready", {63'd0, bus.ready_o}, 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_div(1'b0, 32'd100, 32'd7, "u100_7");
    check("u100_7_model", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, "s_m7_2");
    run_div(1'b1, 32'h00000007, 32'hFFFFFFFE, "s_7_m2");
    run_div(1'b0, 32'h12345678, 32'd0, "byzero");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "wrap");
    run_div(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, "s_m7_m2");
    run_div(1'b0, 32'hFFFFFFFF, 32'h00000001, "u_max_1");

    // Annul pulse at iteration 10 of a running division.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd5000;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
`ifdef DIV_ANNUL_EN
    bus.start_i = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
`ifdef DIV_ANNUL_EN
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) seen = 1'b1;
    end
    check("annul_no_ready", {63'd0, seen}, 64'd0);
    $display("div annul: aborted, ready seen=%0d", seen);
    run_div(1'b0, 32'd9, 32'd3, "after_annul");
`else
    lat = 11;
    while (!bus.ready_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("annul_ignored_latency", 64'(lat), 64'd33);
    check("annul_ignored_result", bus.result_o, ref_div(1'b0, 32'd5000, 32'd7));
    $display("div annul ignored: ready after %0d, result %h", lat, bus.result_o);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
`endif

    // Asynchronous reset at iteration 20.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd123456;
    bus.opdata2_i    = 32'd77;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_ready", {63'd0, bus.ready_o}, 64'd0);
    check("rst_mid_result", bus.result_o, 64'd0);
    $display("div reset mid-division: outputs %h/%0d", bus.result_o, bus.ready_o);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst = 1'b1;
    run_div(1'b0, 32'hFFFFFFFF, 32'h00000010, "after_rst");

    // Asynchronous reset while a result is being held.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    lat = 0;
    @(posedge clk);
    #1;
    while (!bus.ready_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("end_result", bus.result_o, {32'd1, 32'd333});
    #2 rst = 1'b0;
    #1;
    check("rst_end_clear", {bus.result_o[62:0], bus.ready_o}, 64'd0);
    $display("div reset in END: outputs %h/%0d", bus.result_o, bus.ready_o);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 50; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        4: a = b * 32'($urandom_range(0, 3));
        default: ;
      endcase
      run_div(sgn, a, b, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 clk  input  1  core clock; all state changes on the rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; a 0 clears all state immediately, independent of clk.
REQ-003 signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled together with start_i in FREE.
REQ-004 opdata1_i  input  32  dividend; sampled with start_i in FREE.
REQ-005 opdata2_i  input  32  divisor; sampled with start_i in FREE.
REQ-006 start_i  input  1  request from the execute stage; held high until ready_o is seen.
REQ-007 annul_i  input  1  abort the current division (see Configuration).
REQ-008 result_o  output  64  {remainder[63:32], quotient[31:0]}; valid only while ready_o = 1, otherwise 0.
REQ-009 ready_o  output  1  result valid.

Function
REQ-010 The block SHALL be a four-state FSM: FREE, BYZERO, ON, END.
REQ-011 FREE behaviour:
- start_i = 1 and annul inactive, opdata2_i = 0: SHALL go to BYZERO.
- start_i = 1 and annul inactive, opdata2_i != 0: SHALL go to ON, clear the 6-bit cycle counter, and capture the operands and signed flag.
- Otherwise: SHALL stay in FREE.
REQ-012 Operand capture in signed mode: negative operands SHALL be stored as their two's-complement magnitude. Unsigned mode stores raw values. Later input changes SHALL be ignored.
REQ-013 Working register: 65 bits, initialised to {32'b0, |dividend|, 1'b0}.
REQ-014 ON, counter < 32, one restoring step per cycle:
- tmp = {1'b0, work[63:32]} - {1'b0, divisor}.
- tmp[32] = 1: work <= work << 1.
- Else: work <= {tmp[31:0], work[31:0], 1'b1}.
- Counter increments.
REQ-015 ON, counter = 32: SHALL apply the sign fix-up and go to END with ready_o = 1.
- Signed mode, captured operand signs differ: negate the quotient.
- Signed mode, dividend negative: negate the remainder.
- result_o = {work[64:33], work[31:0]} after fix-up.
- Counter cleared.
REQ-016 Latency, nonzero divisor: start sampled at edge E0 -> ready_o and result_o SHALL be high/valid after edge E0+33.
REQ-017 BYZERO: SHALL go to END on the next edge, with result_o = 0 and ready_o = 1 (valid after edge E0+1).
REQ-018 END: SHALL hold ready_o and result_o while start_i = 1. On an edge with start_i = 0, SHALL go to FREE with ready_o = 0 and result_o = 0.
REQ-019 Wrap-around: 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000, remainder 0. No overflow flag.
REQ-020 A new start_i SHALL be accepted only in FREE. There SHALL be no back-to-back acceptance without one FREE cycle.

Reset
REQ-021 On rst = 0, the following SHALL apply asynchronously:
- state = FREE.
- ready_o = 0.
- result_o = 0.
- Counter, working register and captured operands cleared.
REQ-022 Reset mid-division (ON/BYZERO/END) SHALL abandon the operation. After rst returns to 1, the block SHALL accept a new start_i from FREE.

Configuration
REQ-023 Macro DIV_ANNUL_EN:
- Defined: annul_i = 1 in ON or BYZERO SHALL return the FSM to FREE on the next edge, with ready_o = 0 and result_o = 0. annul_i = 1 in FREE SHALL block acceptance of start_i. annul_i SHALL have no effect in END.
- Undefined: the annul_i port SHALL remain present but be ignored entirely.

Verification
REQ-024 Unsigned 100 / 7, start held -> ready_o rises after edge E0+33, result_o = {32'd2, 32'd14}. Deassert start_i -> next edge ready_o = 0, result_o = 0.
REQ-025 Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
REQ-026 Divisor 0, dividend 0x12345678 -> ready_o after edge E0+1, result_o = 0.
REQ-027 With DIV_ANNUL_EN: annul_i pulsed at iteration 10 -> FREE next edge, ready_o never asserts. A following 9 / 3 completes with {0, 3}. Without the macro: the same pulse is ignored and the first result completes.
REQ-028 rst driven low asynchronously between clock edges at iteration 20 -> outputs 0 immediately. After release, unsigned 0xFFFFFFFF / 0x10 -> {0x0000000F, 0x0FFFFFFF}.
